// File: rtl/edge_event_serializer.sv
// Latches per-lane rising-edge pulses as pending events and streams their lane
// indices out over valid/ready with a round-robin arbiter and a saturating drop count.

module edge_event_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic pe,
    input  logic gnt,
    output logic pending,
    output logic drop
);
    // A granted lane with a same-cycle pulse keeps that pulse as the next event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 1'b0;
        else        pending <= gnt ? (pending & pe) : (pending | pe);
    end

    assign drop = pe & pending & ~gnt;
endmodule

module edge_event_serializer #(
    parameter int WIDTH = 9,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pe_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] m_index,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int POP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] req, gnt, drop;
    logic [IDX_W-1:0] rr_ptr, gidx;
    logic [IDX_W:0]   idx;
    logic             gfound, load;
    logic [POP_W-1:0] pop;
    logic [CNT_W:0]   cnt_sum;

    assign req  = pending | pe_in;
    assign load = ~m_valid | m_ready;

    // First requesting lane at or above rr_ptr, wrapping past WIDTH-1 to 0.
    always_comb begin
        gfound = 1'b0;
        gidx   = '0;
        idx    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(WIDTH)) idx = idx - (IDX_W+1)'(WIDTH);
            if (!gfound && req[idx[IDX_W-1:0]]) begin
                gfound = 1'b1;
                gidx   = idx[IDX_W-1:0];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign gnt[i] = load & gfound & (gidx == IDX_W'(i));
        edge_event_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .pe      (pe_in[i]),
            .gnt     (gnt[i]),
            .pending (pending[i]),
            .drop    (drop[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_index <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            if (gfound) begin
                m_valid <= 1'b1;
                m_index <= gidx;
                rr_ptr  <= (gidx == IDX_W'(WIDTH-1)) ? '0 : gidx + 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + POP_W'(drop[i]);
    end

    assign cnt_sum = {1'b0, drop_cnt} + (CNT_W+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          drop_cnt <= '0;
        else if (cnt_sum[CNT_W]) drop_cnt <= '1;
        else                 drop_cnt <= cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_edge_event_serializer.sv
// Randomized and directed checks of edge_event_serializer against a behavioural model.

module tb_edge_event_serializer;
    localparam int WIDTH = 9;
    localparam int IDX_W = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] pe_in = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [IDX_W-1:0] m_index;
    logic [WIDTH-1:0] pending;
    logic [CNT_W-1:0] drop_cnt;

    int errs = 0;
    int checks = 0;

    // behavioural model state
    bit mp[WIDTH];
    bit mv;
    int mi, mrr, mcnt;

    edge_event_serializer #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pe_in    (pe_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_index  (m_index),
        .pending  (pending),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_pending();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) v[i] = mp[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) mp[i] = 1'b0;
        mv = 1'b0; mi = 0; mrr = 0; mcnt = 0;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] pe, input bit rdy);
        bit req[WIDTH];
        bit ld;
        int g, drops;
        for (int i = 0; i < WIDTH; i++) req[i] = mp[i] | pe[i];
        ld = !mv || rdy;
        g = -1;
        if (ld)
            for (int k = 0; k < WIDTH; k++)
                if (g < 0 && req[(mrr + k) % WIDTH]) g = (mrr + k) % WIDTH;
        drops = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == g) mp[i] = mp[i] & pe[i];
            else begin
                if (pe[i] && mp[i]) drops++;
                mp[i] = mp[i] | pe[i];
            end
        end
        if (ld) begin
            if (g >= 0) begin mv = 1'b1; mi = g; mrr = (g + 1) % WIDTH; end
            else mv = 1'b0;
        end
        mcnt = (mcnt + drops > CMAX) ? CMAX : mcnt + drops;
    endtask

    task automatic cmp_model();
        chk("m_valid", 32'(m_valid), 32'(mv));
        chk("m_index", 32'(m_index), 32'(mi));
        chk("pending", 32'(pending), 32'(model_pending()));
        chk("drop_cnt", 32'(drop_cnt), 32'(mcnt));
    endtask

    task automatic step(input logic [WIDTH-1:0] pe, input bit rdy);
        @(negedge clk);
        pe_in = pe;
        m_ready = rdy;
        model_step(pe, rdy);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    // Reset is asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pe_in = '0;
        #1;
        model_reset();
        chk("rst_valid", 32'(m_valid), 32'h0);
        chk("rst_index", 32'(m_index), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // single pulse, one-cycle latency
        step(9'h004, 1'b1);
        chk("t1_valid", 32'(m_valid), 32'h1);
        chk("t1_index", 32'(m_index), 32'h2);
        chk("t1_pending", 32'(pending), 32'h0);
        step(9'h000, 1'b1);
        chk("t1_idle", 32'(m_valid), 32'h0);

        // burst of three lanes drains in order
        do_reset();
        step(9'h111, 1'b1);
        chk("t2_i0", 32'(m_index), 32'h0);
        chk("t2_p0", 32'(pending), 32'h110);
        step(9'h000, 1'b1);
        chk("t2_i1", 32'(m_index), 32'h4);
        chk("t2_p1", 32'(pending), 32'h100);
        step(9'h000, 1'b1);
        chk("t2_i2", 32'(m_index), 32'h8);
        chk("t2_p2", 32'(pending), 32'h000);

        // backpressure: held lane re-pulsed is latched, second re-pulse drops
        do_reset();
        step(9'h008, 1'b1);
        step(9'h008, 1'b0);
        chk("t3_nodrop", 32'(drop_cnt), 32'h0);
        step(9'h000, 1'b0);
        step(9'h008, 1'b0);
        chk("t3_index", 32'(m_index), 32'h3);
        chk("t3_pending", 32'(pending[3]), 32'h1);
        chk("t3_drop", 32'(drop_cnt), 32'h1);

        // round-robin between two always-requesting lanes
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(9'h003, 1'b1);
            chk("t4_alt", 32'(m_index), 32'(i % 2));
        end

        // mid-stream reset with valid output and pending events
        chk("t6_pre_valid", 32'(m_valid), 32'h1);
        chk("t6_pre_pend", 32'(pending != '0), 32'h1);
        do_reset();
        step(9'h004, 1'b1);
        chk("t6_resume", 32'(m_index), 32'h2);

        // drop counter saturation
        do_reset();
        step(9'h1FF, 1'b0);
        while (mcnt + 9 <= CMAX - 1) step(9'h1FF, 1'b0);
        if (mcnt < CMAX - 1) step(9'((1 << (CMAX - 1 - mcnt)) - 1), 1'b0);
        chk("t5_pre", 32'(drop_cnt), 32'(CMAX - 1));
        step(9'h007, 1'b0);
        chk("t5_sat", 32'(drop_cnt), 32'(CMAX));
        step(9'h1FF, 1'b0);
        chk("t5_hold", 32'(drop_cnt), 32'(CMAX));

        // random traffic with random backpressure
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [WIDTH-1:0] pe;
            pe = '0;
            for (int i = 0; i < WIDTH; i++) pe[i] = ($urandom_range(0, 3) == 0);
            step(pe, 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
